// File: rtl/rb_pkg.sv
// Shared constants and handshake port state encoding for the register-bank responder.
package rb_pkg;
  localparam int          NREGS    = 16;
  localparam int          REG_PC   = 15;
  localparam logic [31:0] CPSR_RST = 32'h0000_00D3;

  typedef logic [1:0] hs_state_t;
  localparam hs_state_t HS_IDLE     = 2'd0;
  localparam hs_state_t HS_ACK      = 2'd1;
  localparam hs_state_t HS_WAIT_LOW = 2'd2;
endpackage

// File: rtl/rb_hs_port.sv
// Generic 4-phase return-to-zero responder; fire pulses for the edge a transaction is captured.
module rb_hs_port
  import rb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic trigger,
  output logic ready,
  output logic fire
);
  hs_state_t state;
  // Low for the first edge after reset exit, so a trigger left high across reset is not served.
  logic      armed;

  assign fire  = reset && armed && (state == HS_IDLE) && trigger;
  assign ready = (state == HS_ACK);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= HS_IDLE;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        HS_IDLE:     if (trigger) state <= armed ? HS_ACK : HS_WAIT_LOW;
        HS_ACK:      if (!trigger) state <= HS_IDLE;
        HS_WAIT_LOW: if (!trigger) state <= HS_IDLE;
        default:     state <= HS_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/regbank_responder.sv
// Clocked 16x32 register bank with independent 4-phase read/write ports, r15/pc and cpsr.
// Optional same-edge write-to-read bypass enabled by defining RB_BYPASS_EN.
module regbank_responder
  import rb_pkg::*;
#(
  parameter int          NREGS    = rb_pkg::NREGS,
  parameter logic [31:0] CPSR_RST = rb_pkg::CPSR_RST
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        triggerInr,
  input  logic [31:0] addrr,
  output logic        readyOut,
  output logic [31:0] dataOut,
  input  logic        triggerInw,
  input  logic [31:0] addrw,
  input  logic [31:0] dataIn,
  output logic        readyOutW,
  input  logic [31:0] pcIn,
  input  logic        pcWe,
  output logic [31:0] pcOut,
  input  logic [31:0] cpsrIn,
  input  logic        cpsrWe,
  output logic [31:0] cpsrOut
);
  localparam int             AW     = $clog2(NREGS);
  localparam logic [AW-1:0]  PC_IDX = AW'(REG_PC);

  logic [31:0]   regs [NREGS];
  logic [31:0]   cpsr;
  logic [31:0]   rd_val;
  logic [AW-1:0] ridx, widx;
  logic          rd_fire, wr_fire, pc_load;
  logic          unused_addr;

  assign ridx        = addrr[AW-1:0];
  assign widx        = addrw[AW-1:0];
  assign unused_addr = ^{addrr[31:AW], addrw[31:AW]};

  rb_hs_port u_rd (.clk(clk), .reset(reset), .trigger(triggerInr), .ready(readyOut),  .fire(rd_fire));
  rb_hs_port u_wr (.clk(clk), .reset(reset), .trigger(triggerInw), .ready(readyOutW), .fire(wr_fire));

  // Write port wins r15; the pc load is simply dropped that cycle.
  assign pc_load = pcWe && !(wr_fire && widx == PC_IDX);

  always_comb begin
    rd_val = regs[ridx];
`ifdef RB_BYPASS_EN
    if (wr_fire && widx == ridx)         rd_val = dataIn;
    else if (pc_load && ridx == PC_IDX)  rd_val = pcIn;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      cpsr    <= CPSR_RST;
      dataOut <= '0;
    end else begin
      if (wr_fire) regs[widx]   <= dataIn;
      if (pc_load) regs[PC_IDX] <= pcIn;
      if (cpsrWe)  cpsr         <= cpsrIn;
      if (rd_fire) dataOut      <= rd_val;
    end
  end

  assign pcOut   = regs[PC_IDX];
  assign cpsrOut = cpsr;
endmodule

// File: tb/tb_regbank_responder.sv
// Directed bench for regbank_responder: vector table of port transactions plus corner-case sequences.
module tb_regbank_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        triggerInr, triggerInw, pcWe, cpsrWe;
  logic [31:0] addrr, addrw, dataIn, pcIn, cpsrIn;
  logic        readyOut, readyOutW;
  logic [31:0] dataOut, pcOut, cpsrOut;

  int checks = 0;
  int errors = 0;

  regbank_responder dut (
    .clk(clk), .reset(reset),
    .triggerInr(triggerInr), .addrr(addrr), .readyOut(readyOut), .dataOut(dataOut),
    .triggerInw(triggerInw), .addrw(addrw), .dataIn(dataIn), .readyOutW(readyOutW),
    .pcIn(pcIn), .pcWe(pcWe), .pcOut(pcOut),
    .cpsrIn(cpsrIn), .cpsrWe(cpsrWe), .cpsrOut(cpsrOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;   // write data, or expected read data
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    addrw = a; dataIn = d; triggerInw = 1'b1;
    tick();
    check("wr_ready_rise", {31'b0, readyOutW}, 32'd1);
    triggerInw = 1'b0;
    tick();
    check("wr_ready_fall", {31'b0, readyOutW}, 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp);
    addrr = a; triggerInr = 1'b1;
    tick();
    check("rd_ready_rise", {31'b0, readyOut}, 32'd1);
    check("rd_data", dataOut, exp);
    triggerInr = 1'b0;
    tick();
    check("rd_ready_fall", {31'b0, readyOut}, 32'd0);
    check("rd_data_frozen", dataOut, exp);
  endtask

  initial begin
    logic [31:0] bypass_exp;
`ifdef RB_BYPASS_EN
    bypass_exp = 32'h55;
`else
    bypass_exp = 32'h11;
`endif
    vecs[0] = '{1'b1, 32'd3,          32'hDEADBEEF};
    vecs[1] = '{1'b0, 32'd3,          32'hDEADBEEF};
    vecs[2] = '{1'b1, 32'h0000_0017,  32'h1234_5678};  // upper bits ignored -> r7
    vecs[3] = '{1'b0, 32'd7,          32'h1234_5678};
    vecs[4] = '{1'b0, 32'hABCD_0003,  32'hDEADBEEF};
    vecs[5] = '{1'b0, 32'd1,          32'h0};
    vecs[6] = '{1'b1, 32'd15,         32'h0000_8000};
    vecs[7] = '{1'b0, 32'd15,         32'h0000_8000};

    reset = 1'b0; triggerInr = 0; triggerInw = 0; pcWe = 0; cpsrWe = 0;
    addrr = 0; addrw = 0; dataIn = 0; pcIn = 0; cpsrIn = 0;
    tick(); tick();
    reset = 1'b1;
    tick();
    check("rst_readyOut",  {31'b0, readyOut},  32'd0);
    check("rst_readyOutW", {31'b0, readyOutW}, 32'd0);
    check("rst_pcOut",     pcOut,   32'h0);
    check("rst_cpsrOut",   cpsrOut, 32'hD3);
    check("rst_dataOut",   dataOut, 32'h0);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data);
      else               do_read(vecs[i].addr, vecs[i].data);
    end
    check("pc_after_r15_write", pcOut, 32'h0000_8000);

    // Held trigger: one capture only, data stays frozen while r3 is rewritten.
    addrr = 3; triggerInr = 1'b1;
    tick();
    check("hold_ready", {31'b0, readyOut}, 32'd1);
    addrw = 3; dataIn = 32'hCAFEF00D; triggerInw = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_ready_n", {31'b0, readyOut}, 32'd1);
      check("hold_data_n",  dataOut, 32'hDEADBEEF);
      if (i == 1) triggerInw = 1'b0;
    end
    triggerInr = 1'b0;
    tick();
    check("hold_release", {31'b0, readyOut}, 32'd0);
    do_read(3, 32'hCAFEF00D);

    // Write port beats pcWe on r15.
    addrw = 15; dataIn = 32'h100; triggerInw = 1'b1; pcWe = 1'b1; pcIn = 32'h200;
    tick();
    pcWe = 1'b0; triggerInw = 1'b0;
    check("pc_priority", pcOut, 32'h100);
    tick();
    pcWe = 1'b1; pcIn = 32'h300;
    tick();
    pcWe = 1'b0;
    check("pc_load", pcOut, 32'h300);
    cpsrWe = 1'b1; cpsrIn = 32'h1F;
    tick();
    cpsrWe = 1'b0;
    check("cpsr_load", cpsrOut, 32'h1F);

    // Same-edge read and write of r5.
    do_write(5, 32'h11);
    addrr = 5; addrw = 5; dataIn = 32'h55; triggerInr = 1'b1; triggerInw = 1'b1;
    tick();
    check("same_edge_rd", dataOut, bypass_exp);
    check("same_edge_wr_ready", {31'b0, readyOutW}, 32'd1);
    triggerInr = 1'b0; triggerInw = 1'b0;
    tick();
    do_read(5, 32'h55);

    // Reset mid-handshake with trigger held across reset exit.
    addrr = 3; triggerInr = 1'b1;
    tick();
    check("pre_rst_ready", {31'b0, readyOut}, 32'd1);
    reset = 1'b0;
    tick();
    check("mid_rst_ready", {31'b0, readyOut}, 32'd0);
    check("mid_rst_data",  dataOut, 32'h0);
    check("mid_rst_cpsr",  cpsrOut, 32'hD3);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_resume", {31'b0, readyOut}, 32'd0);
    end
    triggerInr = 1'b0;
    tick();
    check("wait_low_exit", {31'b0, readyOut}, 32'd0);
    triggerInr = 1'b1;
    tick();
    check("post_rst_ack",  {31'b0, readyOut}, 32'd1);
    check("post_rst_data", dataOut, 32'h0);
    triggerInr = 1'b0;
    tick();
    check("post_rst_fall", {31'b0, readyOut}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regbank_responder.md
Name: regbank_responder

Overview:
- Clocked responder for the register-bank side of the trigger/ready handshake that decode initiates as its read requester.
- Serves one read port (decode operand fetch) and one write port (writeback) against a 16 x 32 ARM register file.
- Drives pcOut to fetch and cpsrOut to issuer.
- Replaces the unclocked regbank model; the write port is fully implemented.

Parameters:
- NREGS, 16: number of architectural registers; address uses low log2(NREGS) bits.
- CPSR_RST, 32'h0000_00D3: cpsr value after reset (SVC mode, IRQ/FIQ masked).

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-low reset (sampled on clk rising edge)
- triggerInr  in  1  read request (4-phase level)
- addrr  in  32  read register index; bits [3:0] used
- readyOut  out  1  read acknowledge
- dataOut  out  32  read data, valid while readyOut=1
- triggerInw  in  1  write request (4-phase level)
- addrw  in  32  write register index; bits [3:0] used
- dataIn  in  32  write data
- readyOutW  out  1  write acknowledge
- pcIn  in  32  new PC from fetch
- pcWe  in  1  load pcIn into r15 this cycle
- pcOut  out  32  current r15, combinational from register
- cpsrIn  in  32  new cpsr value
- cpsrWe  in  1  load cpsrIn this cycle
- cpsrOut  out  32  current cpsr

Behaviour:
- Reset (reset=0 at edge):
  - r0..r15 <= 0; cpsr <= CPSR_RST.
  - readyOut, readyOutW <= 0; dataOut <= 0.
  - Both port FSMs go to IDLE. Reset overrides everything, including mid-handshake.
  - The requester must drop trigger; an ACK is never resumed.
- Handshake: 4-phase return-to-zero per port: trigger up -> ready up -> trigger down -> ready down.
- Port FSM states: IDLE, ACK, WAIT_LOW.
  - IDLE, trigger=1 at edge k:
    - Read: capture addrr[3:0]; dataOut <= reg; readyOut <= 1.
    - Write: commit dataIn to reg; readyOutW <= 1.
    - Go to ACK. Latency is 1 edge from trigger sampled high.
  - ACK, trigger=1: hold ready and dataOut stable.
  - ACK, trigger=0 at edge: ready <= 0; go to IDLE.
  - WAIT_LOW is entered only if trigger is still high one edge after reset exit. Stay until trigger=0, then go to IDLE. No new transaction starts until the trigger low phase has been seen.
- dataOut is frozen between transactions; it holds the last read value.
- Read and write ports are independent. Both may capture on the same edge.
- Write priority to r15: write port > pcWe. The lower-priority source is dropped that cycle; no stall.
- cpsrWe loads cpsr on any non-reset edge.
- pcOut = r15 and cpsrOut = cpsr, continuous from the registers.
- addr bits [31:4] are ignored.

Optional Feature:
- Macro: RB_BYPASS_EN
- Defined: if a read captures on the same edge that a write (write port or pcWe) commits to the same register, dataOut gets the new value.
- Undefined: dataOut gets the pre-write value. The write still commits.

Decomposition:
- Package rb_pkg holds:
  - NREGS, REG_PC=15, CPSR_RST
  - port state typedef {IDLE, ACK, WAIT_LOW}
- Sub-module rb_hs_port: generic 4-phase responder FSM.
  - Inputs: trigger. Outputs: ready, fire.
  - Instantiated twice, for the read and write ports.
- Top level holds the storage, r15/cpsr muxing and bypass.

Test Plan:
- Reset, then no activity -> readyOut=0, readyOutW=0, pcOut=0, cpsrOut=32'hD3, dataOut=0.
- Write r3=32'hDEADBEEF, then read r3 -> readyOutW rises 1 edge after triggerInw; after triggerInr, readyOut rises 1 edge later with dataOut=32'hDEADBEEF, and stays until trigger drops, then falls next edge.
- Hold triggerInr high for 5 edges after ack -> exactly one read; readyOut stays 1; dataOut is unchanged even after r3 is rewritten.
- Same edge: write port r15=32'h100 and pcWe with pcIn=32'h200 -> pcOut=32'h100.
- Same-edge read r5 and write r5=32'h55 with prior value 32'h11 -> dataOut=32'h55 if RB_BYPASS_EN is defined, else 32'h11; r5 reads 32'h55 afterward.
- reset=0 while readyOut=1 with trigger held high -> readyOut=0 next edge. After reset release with trigger still high, no ack occurs until trigger is seen low then high again.
